// File: rtl/fp16_pkg.sv
// fp16_pkg: fp16 field layout, canonical quiet NaN, classifiers and feeder FSM states
package fp16_pkg;
  localparam logic [15:0] FP16_QNAN    = 16'h7E00;
  localparam int          FP16_SIGN    = 15;
  localparam int          FP16_EXP_MSB = 14;
  localparam int          FP16_EXP_LSB = 10;
  localparam int          FP16_MAN_MSB = 9;
  localparam logic [4:0]  FP16_EXP_MAX = 5'h1F;
  typedef enum logic {EMPTY, HALF} feed_state_e;
  function automatic logic fp16_is_zero(input logic [15:0] x);
    return x[FP16_EXP_MSB:0] == '0;
  endfunction
  function automatic logic fp16_is_inf(input logic [15:0] x);
    return x[FP16_EXP_MSB:FP16_EXP_LSB] == FP16_EXP_MAX && x[FP16_MAN_MSB:0] == '0;
  endfunction
  function automatic logic fp16_is_nan(input logic [15:0] x);
    return x[FP16_EXP_MSB:FP16_EXP_LSB] == FP16_EXP_MAX && x[FP16_MAN_MSB:0] != '0;
  endfunction
endpackage

// File: rtl/fp16_res_fifo.sv
// fp16_res_fifo: first-word-fall-through sync FIFO; dout reads zero while empty
module fp16_res_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 22
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr, rd;
  assign dout = count != '0 ? mem[rd] : '0;
  always_ff @(posedge clk) if (push) mem[wr] <= din;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr <= '0;
      rd <= '0;
      count <= '0;
    end else begin
      if (push) wr <= wr + 1'b1;
      if (pop) rd <= rd + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
endmodule

// File: rtl/fp16_add_feeder.sv
// fp16_add_feeder: pairs an fp16 stream onto a registered adder, recaptures results into a tagged FIFO.
// Define FP16_ADD_SPECIALS_EN to resolve zero/inf/NaN operands at issue instead of in the adder.
module fp16_add_feeder
  import fp16_pkg::*;
#(
  parameter int ADD_LAT = 1,
  parameter int RES_DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  input  logic             in_last,
  output logic [15:0]      add_a,
  output logic [15:0]      add_b,
  input  logic [15:0]      add_x,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [15:0]      res_data,
  output logic             res_last,
  output logic [TAG_W-1:0] res_tag,
  output logic             res_err
);
  localparam int CW = $clog2(RES_DEPTH) + 1;
  localparam int FW = TAG_W + 18;
  typedef struct packed {
    logic             vld;
    logic [TAG_W-1:0] tag;
    logic             last;
    logic             byp;
    logic [15:0]      bval;
    logic             err;
  } meta_t;
  feed_state_e state, state_nx;
  meta_t [ADD_LAT:0] meta;
  meta_t nm;
  logic [15:0] a_q, opa, opb, push_d;
  logic [TAG_W-1:0] tag;
  logic [CW-1:0] count, inflight;
  logic [FW-1:0] fifo_out;
  logic pair, credit_ok, acc, issue;
  always_comb begin
    inflight = '0;
    for (int i = 0; i <= ADD_LAT; i++) inflight = inflight + CW'(meta[i].vld);
  end
  assign credit_ok = ({1'b0, count} + {1'b0, inflight}) < (CW+1)'(RES_DEPTH);
  assign pair = state == HALF;
  // a lone non-last element needs no FIFO slot, so EMPTY may take it without credit
  assign in_ready = rst & (credit_ok | (~pair & ~in_last));
  assign acc = in_valid & in_ready;
  assign issue = acc & (pair | in_last);
  assign opa = pair ? a_q : in_data;
  assign opb = pair ? in_data : '0;
  always_comb begin
    state_nx = acc ? (pair | in_last ? EMPTY : HALF) : state;
    nm = '0;
    nm.vld = issue;
    nm.tag = tag;
    nm.last = in_last;
    nm.byp = ~pair;
    nm.bval = in_data;
    nm.err = pair & (opa[FP16_SIGN] ^ opb[FP16_SIGN]);
`ifdef FP16_ADD_SPECIALS_EN
    if (pair) begin
      if (fp16_is_nan(opa) | fp16_is_nan(opb)) begin
        nm.byp = 1'b1;
        nm.bval = FP16_QNAN;
        nm.err = 1'b0;
      end else if (fp16_is_zero(opa) | fp16_is_zero(opb)) begin
        nm.byp = 1'b1;
        nm.bval = fp16_is_zero(opa) ? opb : opa;
        nm.err = 1'b0;
      end else if (fp16_is_inf(opa) | fp16_is_inf(opb)) begin
        nm.bval = fp16_is_inf(opa) ? opa : opb;
        nm.byp = ~(fp16_is_inf(opa) & fp16_is_inf(opb) & nm.err);
        nm.err = ~nm.byp;
      end
    end
`endif
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= EMPTY;
      meta <= '0;
      a_q <= '0;
      add_a <= '0;
      add_b <= '0;
      tag <= '0;
    end else begin
      state <= state_nx;
      meta <= {meta[ADD_LAT-1:0], nm};
      if (acc & ~pair) a_q <= in_data;
      if (issue) add_a <= opa;
      if (issue) add_b <= opb;
      if (issue & in_last) tag <= tag + 1'b1;
    end
  assign push_d = meta[ADD_LAT].err ? FP16_QNAN : meta[ADD_LAT].byp ? meta[ADD_LAT].bval : add_x;
  fp16_res_fifo #(.DEPTH(RES_DEPTH), .W(FW)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(meta[ADD_LAT].vld),
    .pop(res_valid & res_ready),
    .din({meta[ADD_LAT].tag, meta[ADD_LAT].last, meta[ADD_LAT].err, push_d}),
    .dout(fifo_out),
    .count(count)
  );
  assign res_valid = count != '0;
  assign {res_tag, res_last, res_err, res_data} = fifo_out;
endmodule

// File: tb/tb_fp16_add_feeder.sv
// tb_fp16_add_feeder: directed and random stream checks against a pairing/tagging reference model
module tb_fp16_add_feeder;
  logic clk = 0, rst = 0, in_valid = 0, in_last = 0;
  logic in_ready, res_valid, res_ready, res_last, res_err;
  logic [15:0] in_data = 0, add_x = 0, add_a, add_b, res_data;
  logic [3:0] res_tag;
  logic rr_force = 0, rr_rand = 0, rr_bit = 0;
  int vectors = 0, errs = 0;
  typedef struct {logic [15:0] d; logic l; logic [3:0] t; logic e;} exp_t;
  exp_t q[$];
  logic have_a = 0;
  logic [15:0] a_m = 0;
  logic [3:0] tag_m = 0;

  fp16_add_feeder dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .add_a(add_a), .add_b(add_b), .add_x(add_x), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data), .res_last(res_last), .res_tag(res_tag), .res_err(res_err)
  );

  always #5 clk = ~clk;
  assign res_ready = rr_rand ? rr_bit : rr_force;
  always @(negedge clk) rr_bit <= 1'($urandom_range(0, 1));

  // external adder: same-sign magnitude add, truncating, one-cycle registered
  function automatic logic [15:0] fadd(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] h, l;
    logic [11:0] mh, ml;
    logic [4:0] e;
    int d;
    {h, l} = (a[14:10] >= b[14:10]) ? {a, b} : {b, a};
    mh = {1'b0, h[14:10] != 0, h[9:0]};
    ml = {1'b0, l[14:10] != 0, l[9:0]};
    d = int'(h[14:10]) - int'(l[14:10]);
    ml = d > 11 ? 12'd0 : ml >> d;
    mh = mh + ml;
    e = h[14:10];
    if (mh[11]) begin
      mh = mh >> 1;
      e = e + 1;
    end
    return {a[15], e, mh[9:0]};
  endfunction
  always @(posedge clk) add_x <= fadd(add_a, add_b);

  // returns {err, data} for an operand pair
  function automatic logic [16:0] model_pair(input logic [15:0] a, input logic [15:0] b);
`ifdef FP16_ADD_SPECIALS_EN
    logic na, nb, za, zb, ia, ib;
    na = a[14:10] == 5'h1F && a[9:0] != 0;
    nb = b[14:10] == 5'h1F && b[9:0] != 0;
    za = a[14:0] == 0;
    zb = b[14:0] == 0;
    ia = a[14:10] == 5'h1F && a[9:0] == 0;
    ib = b[14:10] == 5'h1F && b[9:0] == 0;
    if (na || nb) return {1'b0, 16'h7E00};
    if (za) return {1'b0, b};
    if (zb) return {1'b0, a};
    if (ia && ib) return a[15] == b[15] ? {1'b0, a} : {1'b1, 16'h7E00};
    if (ia) return {1'b0, a};
    if (ib) return {1'b0, b};
`endif
    if (a[15] != b[15]) return {1'b1, 16'h7E00};
    return {1'b0, fadd(a, b)};
  endfunction

  function automatic logic [15:0] rnd_elem();
`ifdef FP16_ADD_SPECIALS_EN
    if ($urandom_range(0, 7) == 0)
      case ($urandom_range(0, 4))
        0: return 16'h0000;
        1: return 16'h7C00;
        2: return 16'hFC00;
        3: return 16'h7E00;
        default: return 16'h8000;
      endcase
`endif
    return {1'($urandom_range(0, 4) == 0), 5'($urandom_range(1, 28)), 10'($urandom)};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    assert (got === want) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", name, got, want);
    end
  endtask

  task automatic push_exp(input logic [15:0] d, input logic l, input logic e);
    exp_t x;
    x.d = d; x.l = l; x.t = tag_m; x.e = e;
    q.push_back(x);
    if (l) tag_m = tag_m + 1;
  endtask

  task automatic accept(input logic [15:0] d, input logic l);
    logic [16:0] r;
    if (!have_a) begin
      if (l) push_exp(d, 1'b1, 1'b0);
      else begin
        a_m = d;
        have_a = 1;
      end
    end else begin
      r = model_pair(a_m, d);
      have_a = 0;
      push_exp(r[15:0], l, r[16]);
    end
  endtask

  task automatic send(input logic [15:0] d, input logic l);
    int n = 0;
    in_valid = 1; in_data = d; in_last = l;
    #1;
    while (!in_ready && n < 500) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      vectors++; errs++;
      $error("FAIL send_timeout: in_ready %b after %0d cycles, 1 required", in_ready, n);
      in_valid = 0;
      return;
    end
    @(posedge clk);
    accept(d, l);
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic chk_reset();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_res_last", res_last, 0);
    chk("rst_res_tag", res_tag, 0);
    chk("rst_res_err", res_err, 0);
    chk("rst_add_a", add_a, 0);
    chk("rst_add_b", add_b, 0);
  endtask

  task automatic do_reset();
    #3 rst = 0;
    in_valid = 0;
    q.delete(); have_a = 0; tag_m = 0;
    #1 chk_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1;
  endtask

  task automatic drain();
    int n = 0;
    rr_rand = 0; rr_force = 1;
    while (q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      vectors++; errs++;
      $error("FAIL drain_timeout: %0d results outstanding, 0 required", q.size());
    end
    @(negedge clk);
    chk("drain_idle", res_valid, 0);
    rr_force = 0;
  endtask

  task automatic pop_check(input string name, input logic [15:0] d, input logic l, input logic [3:0] t, input logic e);
    int n = 0;
    while (!res_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk(name, {res_err, res_tag, res_last, res_data}, {e, t, l, d});
    rr_force = 1;
    @(negedge clk);
    rr_force = 0;
  endtask

  // scoreboard: every popped result must match the model queue head
  always begin
    exp_t e;
    @(negedge clk);
    #2;
    if (rst && res_valid && res_ready) begin
      if (q.size() == 0) begin
        vectors++; errs++;
        $error("FAIL res_unexpected: observed %h, no result expected", res_data);
      end else begin
        e = q.pop_front();
        chk("res", {res_err, res_tag, res_last, res_data}, {e.e, e.t, e.l, e.d});
      end
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    chk_reset();
    rst = 1;
    @(negedge clk);
    send(16'h3C00, 0);
    send(16'h4000, 1);
    chk("lat0_valid", res_valid, 0);
    @(negedge clk);
    chk("lat1_valid", res_valid, 0);
    @(negedge clk);
    chk("lat2_valid", res_valid, 1);
    chk("t1_result", {res_err, res_tag, res_last, res_data}, {1'b0, 4'd0, 1'b1, 16'h4200});
    drain();
    do_reset();
    send(16'h3C00, 0);
    send(16'h3C00, 0);
    send(16'h4200, 1);
    pop_check("t2_pair", 16'h4000, 0, 0, 0);
    pop_check("t2_bypass", 16'h4200, 1, 0, 0);
    send(16'h3C00, 0);
    send(16'hBC00, 1);
    pop_check("t3_sign_err", 16'h7E00, 1, 1, 1);
    for (int i = 0; i < 9; i++) send(rnd_elem(), 0);
    repeat (4) @(negedge clk);
    chk("full_valid", res_valid, 1);
    in_valid = 1; in_data = rnd_elem(); in_last = 0;
    #1 chk("full_in_ready_half", in_ready, 0);
    rr_force = 1;
    send(in_data, 0);
    send(rnd_elem(), 0);
    send(rnd_elem(), 1);
    drain();
    do_reset();
    rr_force = 1;
    for (int g = 0; g < 16; g++) begin
      send(rnd_elem(), 0);
      send(rnd_elem(), 1);
    end
    drain();
    send(16'h3C00, 1);
    pop_check("tag_wrap", 16'h3C00, 1, 0, 0);
    for (int i = 0; i < 5; i++) send(rnd_elem(), 0);
    do_reset();
    @(negedge clk);
    chk("post_rst_valid", res_valid, 0);
    rr_rand = 1;
    for (int i = 0; i < 80; i++) send(rnd_elem(), 1'($urandom_range(0, 2) == 0));
    send(rnd_elem(), 1);
    drain();
`ifdef FP16_ADD_SPECIALS_EN
    do_reset();
    send(16'h0000, 0);
    send(16'h4000, 1);
    pop_check("sp_zero", 16'h4000, 1, 0, 0);
    send(16'h7C00, 0);
    send(16'h3C00, 1);
    pop_check("sp_inf", 16'h7C00, 1, 1, 0);
    send(16'h7E00, 0);
    send(16'h3C00, 1);
    pop_check("sp_nan", 16'h7E00, 1, 2, 0);
    drain();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
